// File: rtl/pll_drp_reconfig.sv
// PLLE2_ADV run-time reprogramming sequencer over DRP: read-modify-write of a
// caller table with the PLL in reset, then release and wait for LOCKED.
// Ports: clk/rst_n, start/busy/done/err, tbl_* lookup, drp_* bus, pll_rst,
// pll_locked (async) and its synchronized copy locked.
`timescale 1ns/1ps
module pll_drp_reconfig #(
  parameter int NUM_REGS     = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [IW-1:0] tbl_idx,
  input  logic [6:0]    tbl_addr,
  input  logic [15:0]   tbl_mask,
  input  logic [15:0]   tbl_data,
  output logic          pll_rst,
  output logic [6:0]    drp_addr,
  output logic          drp_en,
  output logic          drp_we,
  output logic [15:0]   drp_di,
  input  logic [15:0]   drp_do,
  input  logic          drp_rdy,
  input  logic          pll_locked,
  output logic          locked
);

  localparam int TM0  = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int TMAX = (TM0 > RST_HOLD) ? TM0 : RST_HOLD;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT, HOLD, LOCK, FIN
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [15:0]     rdata, rdata_d;
  logic [IW-1:0]   idx_d;
  logic            busy_d, done_d, rst_d, en_d, we_d;
  logic [1:0]      err_d;
  logic [6:0]      addr_d;
  logic [15:0]     di_d;
  logic            sync1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rdata_d = rdata;
    idx_d   = tbl_idx;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    rst_d   = pll_rst;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = drp_addr;
    di_d    = drp_di;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_d   = 2'd0;
          idx_d   = '0;
          busy_d  = 1'b1;
          rst_d   = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        en_d    = 1'b1;
        addr_d  = tbl_addr;
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // DRDY wins over an expiry on the same cycle
        if (drp_rdy) begin
          rdata_d = drp_do;
          state_d = WR;
        end else if (cnt == DRDY_LAST) begin
          err_d   = 2'd1;
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WR: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = tbl_addr;
        di_d    = (rdata & tbl_mask) | (tbl_data & ~tbl_mask);
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_rdy) begin
          cnt_d = '0;
          if (tbl_idx == IDX_LAST) begin
            state_d = HOLD;
          end else begin
            idx_d   = tbl_idx + IW'(1);
            state_d = RD;
          end
        end else if (cnt == DRDY_LAST) begin
          err_d   = 2'd1;
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          rst_d   = 1'b0;
          cnt_d   = '0;
          state_d = LOCK;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      LOCK: begin
        if (locked) begin
          err_d   = 2'd0;
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt == LOCK_LAST) begin
          err_d   = 2'd2;
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      tbl_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 2'd0;
      pll_rst  <= 1'b0;
      drp_en   <= 1'b0;
      drp_we   <= 1'b0;
      drp_addr <= '0;
      drp_di   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rdata    <= rdata_d;
      tbl_idx  <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      pll_rst  <= rst_d;
      drp_en   <= en_d;
      drp_we   <= we_d;
      drp_addr <= addr_d;
      drp_di   <= di_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      locked <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      locked <= sync1;
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig: DRP slave and PLL lock models,
// one task per scenario with inline expected-value checks.
`timescale 1ns/1ps
module tb_pll_drp_reconfig;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  err;
  logic [0:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask, tbl_data;
  logic        pll_rst;
  logic [6:0]  drp_addr;
  logic        drp_en, drp_we;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;
  logic        pll_locked = 1'b0;
  logic        locked;

  int n_chk = 0;
  int n_fail = 0;

  bit zero_lat = 0;
  bit drop_rd = 0;
  bit spur = 0;
  bit lock_en = 1;

  int n_rd = 0, n_wr = 0, n_done = 0, n_ovl = 0;
  int pend = 0;
  logic rdy_q = 1'b0;
  logic en_prev = 1'b0;
  logic [15:0] wd [0:63];
  logic [6:0]  wa [0:63];
  int lcnt = 0;

  pll_drp_reconfig #(
    .NUM_REGS(2), .DRDY_TIMEOUT(255),
    .LOCK_TIMEOUT(65535), .RST_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err(err),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_mask(tbl_mask), .tbl_data(tbl_data),
    .pll_rst(pll_rst), .drp_addr(drp_addr),
    .drp_en(drp_en), .drp_we(drp_we),
    .drp_di(drp_di), .drp_do(drp_do),
    .drp_rdy(drp_rdy), .pll_locked(pll_locked),
    .locked(locked)
  );

  always #5 clk = ~clk;

  always_comb begin
    tbl_addr = (tbl_idx == 1'b0) ? 7'h08 : 7'h09;
    tbl_mask = (tbl_idx == 1'b0) ? 16'hF000 : 16'hFC00;
    tbl_data = (tbl_idx == 1'b0) ? 16'h0145 : 16'h0000;
  end

  assign drp_do  = 16'hA5A5;
  assign drp_rdy = (zero_lat ? drp_en : rdy_q) | spur;

  always @(posedge clk) begin
    rdy_q   <= 1'b0;
    en_prev <= drp_en;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) rdy_q <= 1'b1;
    end
    if (drp_en) begin
      if (pend != 0 || en_prev || !pll_rst) n_ovl <= n_ovl + 1;
      if (drp_we) begin
        wd[n_wr % 64] <= drp_di;
        wa[n_wr % 64] <= drp_addr;
        n_wr <= n_wr + 1;
      end else begin
        n_rd <= n_rd + 1;
      end
      if (!zero_lat && !(drop_rd && !drp_we)) pend <= 2;
    end
    if (done) n_done <= n_done + 1;
  end

  always @(posedge clk) begin
    if (pll_rst || !lock_en) begin
      lcnt <= 0;
      pll_locked <= 1'b0;
    end else if (lcnt == 19) begin
      pll_locked <= 1'b1;
    end else begin
      lcnt <= lcnt + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc, output bit ok);
    ok = 0;
    cyc = 0;
    while (!ok && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({busy, done, err, tbl_idx, pll_rst} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0", {busy, done, err, tbl_idx, pll_rst});
    end
    n_chk++;
    if ({drp_en, drp_we, drp_addr, drp_di, locked} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_drp: got %h want 0", {drp_en, drp_we, drp_addr, drp_di, locked});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_locked: got %b want 1", locked);
    end
  endtask

  task automatic test_basic();
    int r0, w0, d0, cyc;
    bit ok;
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b rst=%b want 1 1", busy, pll_rst);
    end
    wait_done(2000, cyc, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done: no done within %0d cycles", cyc);
    end
    n_chk++;
    if (err !== 2'd0 || pll_rst !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_status: err=%0d rst=%b lk=%b want 0 0 1", err, pll_rst, locked);
    end
    @(negedge clk);
    n_chk++;
    if (n_rd - r0 != 2 || n_wr - w0 != 2 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: rd=%0d wr=%0d done=%0d want 2 2 1",
               n_rd - r0, n_wr - w0, n_done - d0);
    end
    n_chk++;
    if (wd[w0 % 64] !== 16'hA145 || wd[(w0 + 1) % 64] !== 16'hA400) begin
      n_fail++;
      $display("FAIL basic_wdata: got %h %h want a145 a400",
               wd[w0 % 64], wd[(w0 + 1) % 64]);
    end
    n_chk++;
    if (wa[w0 % 64] !== 7'h08 || wa[(w0 + 1) % 64] !== 7'h09) begin
      n_fail++;
      $display("FAIL basic_waddr: got %h %h want 08 09",
               wa[w0 % 64], wa[(w0 + 1) % 64]);
    end
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_drdy_timeout();
    int w0, cyc;
    bit ok;
    w0 = n_wr;
    drop_rd = 1;
    @(negedge clk);
    start = 1'b1;
    wait_done(400, cyc, ok);
    start = 1'b0;
    n_chk++;
    if (!ok || cyc < 256 || cyc > 260) begin
      n_fail++;
      $display("FAIL drdy_to_time: ok=%b cycles=%0d want 256..260", ok, cyc);
    end
    n_chk++;
    if (err !== 2'd1 || pll_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drdy_to_status: err=%0d rst=%b busy=%b want 1 0 0",
               err, pll_rst, busy);
    end
    n_chk++;
    if (n_wr != w0) begin
      n_fail++;
      $display("FAIL drdy_to_nowrite: writes=%0d want 0", n_wr - w0);
    end
    drop_rd = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock_timeout();
    int cyc;
    bit ok;
    lock_en = 0;
    @(negedge clk);
    start = 1'b1;
    wait_done(70000, cyc, ok);
    start = 1'b0;
    n_chk++;
    if (!ok || cyc < 65535 || err !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_to: ok=%b cycles=%0d err=%0d want >=65535 err 2", ok, cyc, err);
    end
    lock_en = 1;
    repeat (3) @(negedge clk);
    pulse_start();
    n_chk++;
    if (err !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_to_clear: err=%0d want 0", err);
    end
    wait_done(2000, cyc, ok);
    n_chk++;
    if (!ok || err !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_rerun: ok=%b err=%0d want 1 0", ok, err);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    int r0, w0, d0, cyc;
    bit ok;
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, cyc, ok);
    repeat (10) @(negedge clk);
    n_chk++;
    if (!ok || n_rd - r0 != 2 || n_wr - w0 != 2 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_start: ok=%b rd=%0d wr=%0d done=%0d want 2 2 1",
               ok, n_rd - r0, n_wr - w0, n_done - d0);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int w0, cyc;
    bit ok;
    w0 = n_wr;
    pulse_start();
    cyc = 0;
    while (n_wr - w0 < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (n_wr - w0 != 2 || tbl_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_reach: wr=%0d idx=%b want 2 1", n_wr - w0, tbl_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err, tbl_idx, pll_rst, drp_en, drp_we} !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_ctl: got %b want 0",
               {busy, done, err, tbl_idx, pll_rst, drp_en, drp_we});
    end
    n_chk++;
    if ({drp_addr, drp_di, locked} !== 24'd0) begin
      n_fail++;
      $display("FAIL arst_drp: got %h want 0", {drp_addr, drp_di, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    pulse_start();
    @(negedge clk);
    n_chk++;
    if (drp_en !== 1'b1 || drp_we !== 1'b0 || drp_addr !== 7'h08 || tbl_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_restart: en=%b we=%b addr=%h idx=%b want 1 0 08 0",
               drp_en, drp_we, drp_addr, tbl_idx);
    end
    wait_done(2000, cyc, ok);
    n_chk++;
    if (!ok || err !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_rerun: ok=%b err=%0d want 1 0", ok, err);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_lat_spurious();
    int r0, w0, d0, cyc;
    bit ok;
    r0 = n_rd; d0 = n_done;
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || n_rd != r0 || n_done != d0 || drp_en !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious: busy=%b rd=%0d done=%0d want 0 0 0",
               busy, n_rd - r0, n_done - d0);
    end
    zero_lat = 1;
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    pulse_start();
    wait_done(2000, cyc, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || err !== 2'd0 || n_rd - r0 != 2 || n_wr - w0 != 2 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_lat: ok=%b err=%0d rd=%0d wr=%0d done=%0d want 1 0 2 2 1",
               ok, err, n_rd - r0, n_wr - w0, n_done - d0);
    end
    n_chk++;
    if (wd[w0 % 64] !== 16'hA145 || wd[(w0 + 1) % 64] !== 16'hA400) begin
      n_fail++;
      $display("FAIL zero_lat_wdata: got %h %h want a145 a400",
               wd[w0 % 64], wd[(w0 + 1) % 64]);
    end
    zero_lat = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drdy_timeout();
    test_lock_timeout();
    test_busy_start();
    test_async_reset();
    test_zero_lat_spurious();
    n_chk++;
    if (n_ovl != 0) begin
      n_fail++;
      $display("FAIL drp_protocol: violations=%0d want 0", n_ovl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
